// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store unit between the single-cycle
// datapath and a req/ack data bus. Freezes the core via Stall while a bus
// transfer is in flight; flags misaligned accesses and bus timeouts on a
// sticky Fault.
//
// Optional feature macro: LSU_BYTE_EN (byte loads/stores via MemByte).
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   MemRead, MemWrite     access strobes (both set => write)
//   MemByte               byte access (only with LSU_BYTE_EN)
//   ALUResult, WriteData  byte address and store data
//   ReadData              registered load result, valid in DONE
//   Stall                 combinational core freeze
//   Fault                 sticky misalign/timeout flag
//   bus_req/we/addr/wdata/be  registered bus request
//   bus_ack, bus_rdata    slave completion strobe and read data
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemByte,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc_c;
  logic [31:0]     read_data_q, read_data_d;
  logic            fault_q, fault_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic [3:0]      bus_be_q, bus_be_d;

  logic            access_c;
  logic            is_byte_c;
  logic            misaligned_c;
  logic [3:0]      be_c;
  logic [31:0]     wdata_c;
  logic [31:0]     load_data_c;

`ifdef LSU_BYTE_EN
  logic       byte_q;
  logic [1:0] lane_q;
  logic [7:0] lane_byte_c;

  // Byte flag and lane are stable while stalled; capture them while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_q <= 1'b0;
      lane_q <= 2'b00;
    end else if (state_q == IDLE) begin
      byte_q <= MemByte;
      lane_q <= ALUResult[1:0];
    end
  end

  // Select the addressed byte lane of the returned word.
  always_comb begin
    lane_byte_c = bus_rdata[7:0];
    unique case (lane_q)
      2'd0: lane_byte_c = bus_rdata[7:0];
      2'd1: lane_byte_c = bus_rdata[15:8];
      2'd2: lane_byte_c = bus_rdata[23:16];
      2'd3: lane_byte_c = bus_rdata[31:24];
      default: lane_byte_c = bus_rdata[7:0];
    endcase
  end

  assign is_byte_c   = MemByte;
  assign be_c        = MemByte ? 4'(4'b0001 << ALUResult[1:0]) : 4'hF;
  assign wdata_c     = MemByte ? {4{WriteData[7:0]}} : WriteData;
  assign load_data_c = byte_q ? {24'd0, lane_byte_c} : bus_rdata;
`else
  logic unused_mem_byte;

  assign unused_mem_byte = MemByte;
  assign is_byte_c       = 1'b0;
  assign be_c            = 4'hF;
  assign wdata_c         = WriteData;
  assign load_data_c     = bus_rdata;
`endif

  assign access_c     = MemRead | MemWrite;
  assign misaligned_c = !is_byte_c && (ALUResult[1:0] != 2'b00);
  assign cnt_inc_c    = cnt_q + CntW'(1);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
      fault_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
    end
  end

  // Next-state, bus request and Stall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    fault_d     = fault_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    Stall       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (access_c) begin
          Stall = 1'b1;
          if (misaligned_c) begin
            state_d     = DONE;
            fault_d     = 1'b1;
            read_data_d = '0;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = MemWrite;
            bus_addr_d  = {ALUResult[31:2], 2'b00};
            bus_wdata_d = wdata_c;
            bus_be_d    = be_c;
          end
        end
      end
      REQ: begin
        Stall   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        Stall = 1'b1;
        // Ack wins over a timeout landing in the same cycle.
        if (bus_ack) begin
          state_d     = DONE;
          bus_req_d   = 1'b0;
          read_data_d = bus_we_q ? 32'd0 : load_data_c;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CntW'(TIMEOUT)) begin
            state_d     = DONE;
            bus_req_d   = 1'b0;
            fault_d     = 1'b1;
            read_data_d = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ReadData  = read_data_q;
  assign Fault     = fault_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected access results are queued
// when an access is launched and compared when the unit reaches DONE.
module tb_mem_access_unit;

  localparam int unsigned TIMEOUT = 15;
  localparam int MaxCycles = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, MemByte;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        Stall, Fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemByte   (MemByte),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Fault     (Fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Launch one access; ack_at = WAIT cycle carrying the ack (0 = never),
  // early_ack additionally pulses ack during REQ where it must be ignored.
  task automatic access(input string name,
                        input logic rd, input logic wr, input logic byt,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_at, input logic early_ack,
                        input logic [31:0] rdata,
                        input logic [31:0] exp_rd, input logic exp_fault,
                        input int exp_stalls, input int exp_reqs,
                        input logic exp_we, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata);
    exp_t e;
    exp_t got;
    int   stalls;
    int   reqs;
    bit   done;
    e.rdata = exp_rd; e.fault = exp_fault; e.stalls = exp_stalls; e.reqs = exp_reqs;
    sb.push_back(e);
    stalls = 0; reqs = 0; done = 1'b0;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; MemByte = byt;
    ALUResult = addr; WriteData = wdata; bus_rdata = rdata; bus_ack = 1'b0;
    #1;
    for (int cyc = 0; cyc < MaxCycles && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus_ack = 1'b0;
      if (bus_req) begin
        reqs++;
        if (reqs == 1 || (ack_at > 0 && reqs == ack_at + 1)) begin
          check({name, ":bus_addr"},  bus_addr, {addr[31:2], 2'b00});
          check({name, ":bus_we"},    32'(bus_we), 32'(exp_we));
          check({name, ":bus_be"},    32'(bus_be), 32'(exp_be));
          check({name, ":bus_wdata"}, bus_wdata, exp_wdata);
        end
        bus_ack = (ack_at > 0 && reqs == ack_at + 1) || (early_ack && reqs == 1);
      end
      if (Stall) begin
        stalls++;
      end else begin
        done = 1'b1;
        got = sb.pop_front();
        check({name, ":ReadData"}, ReadData, got.rdata);
        check({name, ":Fault"},    32'(Fault), 32'(got.fault));
        check({name, ":stalls"},   32'(stalls), 32'(got.stalls));
        check({name, ":bus_reqs"}, 32'(reqs), 32'(got.reqs));
      end
    end
    if (!done) begin
      void'(sb.pop_front());
      check({name, ":reached_done"}, 32'(done), 32'd1);
    end
    MemRead = 1'b0; MemWrite = 1'b0; MemByte = 1'b0; bus_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; MemByte = 1'b0;
    ALUResult = '0; WriteData = '0; bus_ack = 1'b0; bus_rdata = '0;
    do_reset();

    #1;
    check("rst:ReadData",  ReadData, 32'd0);
    check("rst:Fault",     32'(Fault), 32'd0);
    check("rst:bus_req",   32'(bus_req), 32'd0);
    check("rst:bus_we",    32'(bus_we), 32'd0);
    check("rst:bus_addr",  bus_addr, 32'd0);
    check("rst:bus_wdata", bus_wdata, 32'd0);
    check("rst:bus_be",    32'(bus_be), 32'd0);
    check("rst:Stall",     32'(Stall), 32'd0);

    //      name        rd    wr    byt   addr           wdata          ack early rdata          exp_rd         f     st  rq  we    be     exp_wdata
    access("ld_100",   1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,          2, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0,  4,  3, 1'b0, 4'hF, 32'h0);
    access("st_40",    1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678,  1, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b0,  3,  2, 1'b1, 4'hF, 32'h1234_5678);
    access("rdwr_44",  1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0BAD_CAFE,  1, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b0,  3,  2, 1'b1, 4'hF, 32'h0BAD_CAFE);
    access("ld_early", 1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0,          3, 1'b1, 32'h5A5A_1234, 32'h5A5A_1234, 1'b0,  5,  4, 1'b0, 4'hF, 32'h0);
    access("ld_edge",  1'b1, 1'b0, 1'b0, 32'h0000_0084, 32'h0,         15, 1'b0, 32'h600D_F00D, 32'h600D_F00D, 1'b0, 17, 16, 1'b0, 4'hF, 32'h0);
    access("ld_tmo",   1'b1, 1'b0, 1'b0, 32'h0000_0088, 32'h0,          0, 1'b0, 32'h7777_7777, 32'h0,         1'b1, 17, 16, 1'b0, 4'hF, 32'h0);
    access("st_tmo",   1'b0, 1'b1, 1'b0, 32'h0000_008C, 32'hA5A5_A5A5,  0, 1'b0, 32'h0,         32'h0,         1'b1, 17, 16, 1'b1, 4'hF, 32'hA5A5_A5A5);

    do_reset();
    access("ld_10",    1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,          1, 1'b0, 32'h1111_1111, 32'h1111_1111, 1'b0,  3,  2, 1'b0, 4'hF, 32'h0);
    access("ld_mis",   1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'h0,          1, 1'b0, 32'h9999_9999, 32'h0,         1'b1,  1,  0, 1'b0, 4'hF, 32'h0);
    access("ld_20",    1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0,          1, 1'b0, 32'h2222_2222, 32'h2222_2222, 1'b1,  3,  2, 1'b0, 4'hF, 32'h0);
    access("st_mis",   1'b0, 1'b1, 1'b0, 32'h0000_0041, 32'h3333_3333,  1, 1'b0, 32'h0,         32'h0,         1'b1,  1,  0, 1'b1, 4'hF, 32'h0);
`ifdef LSU_BYTE_EN
    access("strb_203", 1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'h1234_56AB,  1, 1'b0, 32'h0,         32'h0,         1'b1,  3,  2, 1'b1, 4'h8, 32'hABAB_ABAB);
    access("ldrb_201", 1'b1, 1'b0, 1'b1, 32'h0000_0201, 32'h0,          1, 1'b0, 32'h1122_3344, 32'h0000_0033, 1'b1,  3,  2, 1'b0, 4'h2, 32'h0);
`else
    access("byte_mis", 1'b1, 1'b0, 1'b1, 32'h0000_0203, 32'h0,          1, 1'b0, 32'h1122_3344, 32'h0,         1'b1,  1,  0, 1'b0, 4'hF, 32'h0);
    access("byte_wd",  1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0,          1, 1'b0, 32'h1122_3344, 32'h1122_3344, 1'b1,  3,  2, 1'b0, 4'hF, 32'h0);
`endif

    // Reset lands while waiting for the slave; the late ack must be ignored.
    do_reset();
    @(negedge clk);
    MemRead = 1'b1; ALUResult = 32'h0000_0300; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rstwait:req_in_REQ", 32'(bus_req), 32'd1);
    @(negedge clk);
    check("rstwait:req_in_WAIT", 32'(bus_req), 32'd1);
    reset = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b0; bus_ack = 1'b1;
    check("rstwait:req_after_rst", 32'(bus_req), 32'd0);
    check("rstwait:stall_idle",    32'(Stall), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    check("rstwait:req_after_ack", 32'(bus_req), 32'd0);
    check("rstwait:ReadData",      ReadData, 32'd0);
    check("rstwait:Fault",         32'(Fault), 32'd0);
    check("rstwait:stall",         32'(Stall), 32'd0);
    access("ld_304",   1'b1, 1'b0, 1'b0, 32'h0000_0304, 32'h0,          1, 1'b0, 32'h4444_4444, 32'h4444_4444, 1'b0,  3,  2, 1'b0, 4'hF, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
